// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

    // Loader sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_LO = 3'd1,
        HDR_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    // Header is a 16-bit little-endian word count.
    localparam int HDR_BYTES      = 2;
    // Instruction words arrive as four little-endian bytes.
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream handshake into the loader (e.g. from a UART receiver).
// Latency: n/a (wires only).
// Backpressure: a byte moves only on a cycle where rx_valid and rx_ready are both high.
// Ports: rx_data (byte), rx_valid (source has a byte), rx_ready (sink accepts it).
interface imem_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes into a 32-bit little-endian word, lane 0 first.
// Latency: o_word is look-ahead; it already contains the byte strobed this cycle.
// Backpressure: none; the caller strobes only on accepted bytes.
// Ports: clk/reset_n, i_byte + i_stb (byte to place), i_clr (restart at lane 0),
//        o_word (assembled word incl. current byte), o_lane (lane the next byte lands in).
module word_assembler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  i_byte,
    input  logic        i_stb,
    input  logic        i_clr,
    output logic [31:0] o_word,
    output logic [1:0]  o_lane
);
    logic [31:0] r_word;
    logic [1:0]  r_lane;
    logic [31:0] w_word_next;

    // Merging the in-flight byte lets the owner capture a complete word on
    // the same edge the last byte transfers, without an extra pipeline stage.
    always_comb begin
        w_word_next = r_word;
        if (i_stb) begin
            w_word_next[{r_lane, 3'b000} +: 8] = i_byte;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word <= '0;
            r_lane <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_lane <= '0;
        end else if (i_stb) begin
            r_word <= w_word_next;
            // Two-bit counter wraps back to lane 0 after the fourth byte.
            r_lane <= r_lane + 2'd1;
        end
    end

    assign o_word = w_word_next;
    assign o_lane = r_lane;
endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a counted little-endian image into instruction RAM, holding the CPU until done.
// Latency: write pulse 1 cycle after a word's 4th byte; load_done/cpu_hold change 1 cycle after the last write.
// Backpressure: rx_ready high only in HDR_LO/HDR_HI/DATA, so >= 5 cycles per word (low during WRITE).
// Ports: clk, reset_n (async, active low), rx (byte stream, slave side), load_req (restart pulse),
//        imem_we/imem_waddr/imem_wdata (RAM write port), cpu_hold, load_done, load_err (status levels).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_DEPTH  = 1024,
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int          CNT_W      = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    imem_loader_if.slave   rx,
    input  logic           load_req,
    output logic           imem_we,
    output logic [31:0]    imem_waddr,
    output logic [31:0]    imem_wdata,
    output logic           cpu_hold,
    output logic           load_done,
    output logic           load_err
);
    // One extra bit so an index equal to MEM_DEPTH is representable.
    localparam int IDX_W = $clog2(MEM_DEPTH) + 1;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_word_idx;
    logic               r_we;
    logic [31:0]        r_waddr;
    logic [31:0]        r_wdata;
    logic               r_cpu_hold;
    logic               r_load_done;
    logic               r_load_err;

    logic               w_rx_ready;
    logic               w_xfer;
    logic               w_byte_stb;
    logic               w_asm_clr;
    logic [31:0]        w_word;
    logic [1:0]         w_lane;
    logic [CNT_W-1:0]   w_hdr_count;
    logic               w_last_word;

    assign w_rx_ready  = (r_state == HDR_LO) || (r_state == HDR_HI) || (r_state == DATA);
    assign w_xfer      = rx.rx_valid && w_rx_ready;
    assign w_byte_stb  = w_xfer && (r_state == DATA);
    // Clearing on the high header byte restarts the lane counter for every load,
    // including one that follows a reset or an aborted image.
    assign w_asm_clr   = w_xfer && (r_state == HDR_HI);
    assign w_hdr_count = CNT_W'({rx.rx_data, r_count[7:0]});
    assign w_last_word = ({{(CNT_W-IDX_W){1'b0}}, r_word_idx} + CNT_W'(1)) == r_count;

    word_assembler u_word_assembler (
        .clk     (clk),
        .reset_n (reset_n),
        .i_byte  (rx.rx_data),
        .i_stb   (w_byte_stb),
        .i_clr   (w_asm_clr),
        .o_word  (w_word),
        .o_lane  (w_lane)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_word_idx  <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state <= HDR_LO;
                end
                HDR_LO: begin
                    if (w_xfer) begin
                        r_count[7:0] <= rx.rx_data;
                        r_state      <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (w_xfer) begin
                        r_count <= w_hdr_count;
                        if (w_hdr_count == '0) begin
                            r_state     <= DONE;
                            r_cpu_hold  <= 1'b0;
                            r_load_done <= 1'b1;
                        end else if (w_hdr_count > CNT_W'(MEM_DEPTH)) begin
                            r_state    <= ERR;
                            r_load_err <= 1'b1;
                        end else begin
                            r_state    <= DATA;
                            r_word_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    // Register the write port on the final byte so the pulse
                    // coincides with the single WRITE cycle.
                    if (w_byte_stb && (w_lane == 2'(BYTES_PER_WORD - 1))) begin
                        r_state <= WRITE;
                        r_we    <= 1'b1;
                        r_waddr <= START_ADDR + 32'({r_word_idx, 2'b00});
                        r_wdata <= w_word;
                    end
                end
                WRITE: begin
                    r_word_idx <= r_word_idx + 1'b1;
                    if (w_last_word) begin
                        r_state     <= DONE;
                        r_cpu_hold  <= 1'b0;
                        r_load_done <= 1'b1;
                    end else begin
                        r_state <= DATA;
                    end
                end
                DONE: begin
                    if (load_req) begin
                        r_state     <= HDR_LO;
                        r_cpu_hold  <= 1'b1;
                        r_load_done <= 1'b0;
                    end
                end
                ERR: begin
                    if (load_req) begin
                        r_state    <= HDR_LO;
                        r_load_err <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rx.rx_ready = w_rx_ready;
    assign imem_we     = r_we;
    assign imem_waddr  = r_waddr;
    assign imem_wdata  = r_wdata;
    assign cpu_hold    = r_cpu_hold;
    assign load_done   = r_load_done;
    assign load_err    = r_load_err;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: image loads, zero/oversize headers, gaps, reset mid-load, full depth.
// Latency: checks write pulse one cycle after each word's 4th byte and status one cycle after the last write.
// Backpressure: source holds each byte until rx_ready; rx_ready must be low whenever imem_we is high.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int LIMIT = 50;

    logic        clk;
    logic        reset_n;
    logic        load_req;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    imem_loader_if rx_if ();

    imem_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx_if.slave),
        .load_req   (load_req),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] img [0:1023];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor: log every write and confirm the source is stalled in that cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_waddr);
            wr_data_q.push_back(imem_wdata);
            chk_eq("rdy_low_in_write", {31'd0, rx_if.rx_ready}, 32'd0);
        end
    end

    // Entered and left at a negedge; returns on the negedge right after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        n = 0;
        while (rx_if.rx_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk_eq("rdy_wait", {31'd0, (n < LIMIT)}, 32'd1);
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'hA5;
    endtask

    function automatic int pick_gap(input int maxgap);
        return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
    endfunction

    task automatic send_hdr(input int cnt, input int maxgap);
        logic [15:0] hdr;
        hdr = cnt[15:0];
        for (int k = 0; k < HDR_BYTES; k++) send_byte(hdr[k*8 +: 8], pick_gap(maxgap));
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int b = 0; b < BYTES_PER_WORD; b++) send_byte(w[b*8 +: 8], pick_gap(maxgap));
        chk_eq("we_latency", {31'd0, imem_we}, 32'd1);
    endtask

    task automatic send_img(input int cnt, input int nwords, input int maxgap);
        send_hdr(cnt, maxgap);
        for (int i = 0; i < nwords; i++) send_word(img[i], maxgap);
    endtask

    task automatic chk_writes(input int n);
        chk_eq("wr_count", wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            chk_eq("wr_addr", wr_addr_q[i], 32'(4 * i));
            chk_eq("wr_data", wr_data_q[i], img[i]);
        end
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // After the last word's write cycle, status flips on the next cycle.
    task automatic chk_finish(input string tag);
        chk_eq({tag, "_done_pre"}, {31'd0, load_done}, 32'd0);
        chk_eq({tag, "_hold_pre"}, {31'd0, cpu_hold}, 32'd1);
        @(negedge clk);
        chk_eq({tag, "_done"}, {31'd0, load_done}, 32'd1);
        chk_eq({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk_eq({tag, "_rdy"}, {31'd0, rx_if.rx_ready}, 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_eq({tag, "_rdy"},   {31'd0, rx_if.rx_ready}, 32'd0);
        chk_eq({tag, "_we"},    {31'd0, imem_we}, 32'd0);
        chk_eq({tag, "_waddr"}, imem_waddr, 32'd0);
        chk_eq({tag, "_wdata"}, imem_wdata, 32'd0);
        chk_eq({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
        chk_eq({tag, "_done"},  {31'd0, load_done}, 32'd0);
        chk_eq({tag, "_err"},   {31'd0, load_err}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        load_req       = 1'b0;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset_n = 1'b1;

        // Two-word image from a literal byte stream.
        img[0] = 32'h00C30413;
        img[1] = 32'h00800267;
        send_img(2, 2, 0);
        chk_finish("t2w");
        chk_writes(2);
        chk_eq("t2w_addr1", wr_addr_q[1], 32'h4);
        chk_eq("t2w_data1", wr_data_q[1], 32'h00800267);

        // Zero-length image.
        wr_addr_q.delete(); wr_data_q.delete();
        pulse_load_req();
        chk_eq("zl_hold_req", {31'd0, cpu_hold}, 32'd1);
        chk_eq("zl_done_req", {31'd0, load_done}, 32'd0);
        chk_eq("zl_rdy_req", {31'd0, rx_if.rx_ready}, 32'd1);
        send_hdr(0, 0);
        chk_eq("zl_done", {31'd0, load_done}, 32'd1);
        chk_eq("zl_hold", {31'd0, cpu_hold}, 32'd0);
        @(negedge clk);
        chk_eq("zl_writes", wr_addr_q.size(), 0);

        // Oversize header, bytes refused in ERR, then recovery.
        pulse_load_req();
        send_hdr(1025, 0);
        chk_eq("ov_err", {31'd0, load_err}, 32'd1);
        chk_eq("ov_hold", {31'd0, cpu_hold}, 32'd1);
        chk_eq("ov_done", {31'd0, load_done}, 32'd0);
        rx_if.rx_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_eq("ov_rdy", {31'd0, rx_if.rx_ready}, 32'd0);
        end
        rx_if.rx_valid = 1'b0;
        chk_eq("ov_err_hold", {31'd0, load_err}, 32'd1);
        pulse_load_req();
        chk_eq("ov_err_clr", {31'd0, load_err}, 32'd0);
        chk_eq("ov_hold_clr", {31'd0, cpu_hold}, 32'd1);
        img[0] = 32'hDEADBEEF;
        send_img(1, 1, 0);
        chk_finish("ov1");
        chk_writes(1);

        // Four words with random source gaps.
        wr_addr_q.delete(); wr_data_q.delete();
        pulse_load_req();
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        send_img(4, 4, 7);
        chk_finish("gap");
        chk_writes(4);

        // Reset after two bytes of the second word.
        wr_addr_q.delete(); wr_data_q.delete();
        pulse_load_req();
        img[0] = 32'h12345678;
        send_hdr(2, 0);
        send_word(img[0], 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        chk_eq("mid_wdata_pre", imem_wdata, 32'h12345678);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("mid");
        @(negedge clk);
        reset_n = 1'b1;
        wr_addr_q.delete(); wr_data_q.delete();
        img[0] = 32'hCAFEF00D;
        send_img(1, 1, 0);
        chk_finish("mid1");
        chk_writes(1);

        // Full-depth image, word i holds i.
        wr_addr_q.delete(); wr_data_q.delete();
        pulse_load_req();
        for (int i = 0; i < 1024; i++) img[i] = 32'(i);
        send_img(1024, 1024, 0);
        chk_finish("full");
        chk_writes(1024);
        chk_eq("full_last_addr", wr_addr_q[wr_addr_q.size()-1], 32'hFFC);
        chk_eq("full_last_data", wr_data_q[wr_data_q.size()-1], 32'h3FF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader. It is the write side of the instruction memory that the core's fetch path reads.
- Accepts a little-endian byte stream over a valid/ready handshake, for example from a UART receiver.
- Assembles the bytes into 32-bit instruction words and writes them sequentially into a writable instruction RAM.
- Holds the CPU in reset (`cpu_hold`) until the image is loaded, so fetch starts at `START_ADDR` with a valid program.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in the instruction RAM; the upper bound on image length.
- START_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.
- CNT_W, 16, width of the word-count header field.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming stream byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid and rx_ready are both high.
- load_req  input  1  single-cycle pulse that restarts loading; honoured only in DONE or ERR.
- imem_we  output  1  instruction RAM write enable; one-cycle pulse per word.
- imem_waddr  output  32  byte address of the write; always word aligned.
- imem_wdata  output  32  instruction word to write.
- cpu_hold  output  1  keeps the core in reset while high.
- load_done  output  1  image fully written; level signal.
- load_err  output  1  header word count exceeded MEM_DEPTH; level signal.

Behaviour:
- Reset values (while reset_n is low):
  - state = IDLE.
  - rx_ready = 0, imem_we = 0, imem_waddr = 0, imem_wdata = 0.
  - cpu_hold = 1, load_done = 0, load_err = 0.
  - Internal word index = 0, byte index = 0, count = 0.
- Stream format:
  - Byte 0 is count[7:0], byte 1 is count[15:8].
  - Then count words follow, each sent as 4 bytes, least significant byte first.
- Handshake rules:
  - rx_ready is decoded from state: high only in HDR_LO, HDR_HI and DATA.
  - A byte is consumed only on a cycle where rx_valid and rx_ready are both high.
  - rx_data is ignored while rx_valid is low; gaps of any length are legal.
- State machine:
  - IDLE -> HDR_LO unconditionally on the first clock after reset release.
  - HDR_LO, on a transfer: latch count[7:0] -> HDR_HI.
  - HDR_HI, on a transfer, latch count[15:8], then:
    - if count == 0 -> DONE;
    - else if count > MEM_DEPTH -> ERR;
    - else -> DATA, with word index = 0 and byte index = 0.
  - DATA, on a transfer:
    - place the byte at lane byte_idx of the word buffer, then byte_idx += 1;
    - on the 4th byte (byte_idx == 3) -> WRITE.
  - WRITE (exactly one cycle):
    - imem_we = 1, imem_waddr = START_ADDR + 4*word_idx, imem_wdata = the assembled word;
    - word_idx += 1;
    - if word_idx + 1 == count -> DONE, else -> DATA.
  - DONE: cpu_hold = 0, load_done = 1. load_req -> HDR_LO with cpu_hold = 1 and load_done = 0, both in the same cycle as the transition.
  - ERR: cpu_hold = 1, load_err = 1. load_req -> HDR_LO and clears load_err.
  - load_req in any other state is ignored.
- Latency and throughput:
  - If the 4th byte of a word transfers in cycle N, imem_we is high in cycle N+1.
  - Minimum 5 cycles per word, because rx_ready is low during WRITE.
  - From the last write, load_done rises and cpu_hold falls 1 cycle later.
- Outputs: imem_we, imem_waddr and imem_wdata are registered. imem_waddr and imem_wdata hold their last values when imem_we is low.
- Arithmetic and widths:
  - word_idx is clog2(MEM_DEPTH)+1 bits wide, so a count equal to MEM_DEPTH is exactly reachable.
  - Addresses never wrap, because count is limited to MEM_DEPTH.
- Boundary conditions:
  - count == MEM_DEPTH is legal: the last write goes to START_ADDR + 4*(MEM_DEPTH-1).
  - Asserting reset_n low mid-load immediately returns to the reset values (cpu_hold = 1). A partially written image is not erased; the next load overwrites it.
  - Bytes arriving in DONE or ERR are not accepted (rx_ready = 0).

Decomposition:
- Shared package `imem_loader_pkg` holds:
  - the state enum: IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR;
  - HDR_BYTES = 2 and BYTES_PER_WORD = 4.
- One sub-module, `word_assembler`:
  - accepts a byte, a byte-lane strobe and a clear input;
  - outputs the 32-bit little-endian word and a 2-bit lane counter.
- The FSM, counters and write port stay in `imem_loader`.

Test Plan:
- Image of 2 words: stream 02 00 | 13 04 C3 00 | 67 02 80 00 -> imem_we pulses twice:
  - first: addr 0x0, data 0x00C30413;
  - second: addr 0x4, data 0x00800267;
  - then load_done = 1 and cpu_hold = 0.
- Zero-length image: stream 00 00 -> DONE 1 cycle after the second byte; no imem_we pulses.
- Oversize image: header 0x0401 (1025 words) -> ERR, load_err = 1, cpu_hold stays 1. A following load_req plus a valid 1-word image -> load_err cleared, 1 write, DONE.
- Backpressure and gaps:
  - insert random rx_valid gaps of 0–7 cycles;
  - check that no byte is lost or duplicated and that rx_ready is low during every WRITE cycle;
  - 4 words must produce 4 writes at 0x0, 0x4, 0x8, 0xC.
- Reset mid-load: assert reset_n low after byte 2 of word 1 -> all outputs return to reset values. A fresh 1-word image afterwards writes addr 0x0 with the correct data.
- Full-depth image: load MEM_DEPTH words with data equal to the word index -> last write at addr 0xFFC with data 0x3FF, then load_done = 1.
